fifo_sync_param: RTL and testbench

- Parametrised single-clock synchronous FIFO; next generation of the team's small push/pop FIFO.
- Adds arbitrary (non-power-of-two) depth and count-based full/empty, so a stored all-zero word is valid data.
- Adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between a producer and a consumer, both using the push/pop handshake.

---
 rtl/fifo_sync_param_if.sv | 31 +++
 rtl/fifo_sync_param.sv | 105 ++++++++++
 tb/tb_fifo_sync_param.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_param_if.sv
// rtl/fifo_sync_param_if.sv - push/pop handshake, read data and status bundle for fifo_sync_param
interface fifo_sync_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  logic                           push;
  logic [WIDTH-1:0]               data_in;
  logic                           pop;
  logic                           clr_err;
  logic [WIDTH-1:0]               data_out;
  logic                           out_valid;
  logic                           full;
  logic                           empty;
  logic                           almost_full;
  logic                           almost_empty;
  logic [$clog2(DEPTH+1)-1:0]     count;
  logic                           overflow;
  logic                           underflow;

  modport master (
    output push, data_in, pop, clr_err,
    input  data_out, out_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  push, data_in, pop, clr_err,
    output data_out, out_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - single-clock FIFO, any depth, count-based flags, sticky errors, optional FWFT
module fifo_sync_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rstn,
  fifo_sync_param_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AFULL_TH);
  localparam logic [CW-1:0] AE_LVL   = CW'(AEMPTY_TH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             full_i;
  logic             empty_i;
  logic             pop_acc;
  logic             push_acc;
  logic             ovf;
  logic             udf;

  // Explicit wrap so non-power-of-two depths use every slot exactly once.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign empty_i  = (cnt == '0);
  assign full_i   = (cnt == FULL_LVL);
  assign pop_acc  = bus.pop && !empty_i;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_acc = bus.push && (!full_i || pop_acc);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_acc) wr_ptr <= next_ptr(wr_ptr);
      if (pop_acc)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_acc, pop_acc})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc && rstn) mem[wr_ptr] <= bus.data_in;
  end

  // Setting an error takes priority over clearing it in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (bus.push && !push_acc) ovf <= 1'b1;
      else if (bus.clr_err)      ovf <= 1'b0;
      if (bus.pop && !pop_acc)   udf <= 1'b1;
      else if (bus.clr_err)      udf <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out  = empty_i ? '0 : mem[rd_ptr];
      assign bus.out_valid = !empty_i;
    end else begin : g_reg
      logic [WIDTH-1:0] dout;
      logic             vld;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          dout <= '0;
          vld  <= 1'b0;
        end else begin
          vld <= pop_acc;
          if (pop_acc) dout <= mem[rd_ptr];
        end
      end

      assign bus.data_out  = dout;
      assign bus.out_valid = vld;
    end
  endgenerate

  assign bus.full         = full_i;
  assign bus.empty        = empty_i;
  assign bus.almost_full  = (cnt >= AF_LVL);
  assign bus.almost_empty = (cnt <= AE_LVL);
  assign bus.count        = cnt;
  assign bus.overflow     = ovf;
  assign bus.underflow    = udf;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - directed bench over depth-5 registered, depth-5 FWFT and depth-16 instances
module tb_fifo_sync_param;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fifo_sync_param_if #(.WIDTH(8), .DEPTH(5))  ifa ();
  fifo_sync_param_if #(.WIDTH(8), .DEPTH(5))  ifb ();
  fifo_sync_param_if #(.WIDTH(8), .DEPTH(16)) ifc ();

  fifo_sync_param #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u_a (.clk(clk), .rstn(rstn), .bus(ifa));
  fifo_sync_param #(.WIDTH(8), .DEPTH(5), .FWFT(1)) u_b (.clk(clk), .rstn(rstn), .bus(ifb));
  fifo_sync_param #(.WIDTH(8), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(0))
    u_c (.clk(clk), .rstn(rstn), .bus(ifc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {ifa.push, ifa.pop, ifa.clr_err} = '0; ifa.data_in = '0;
    {ifb.push, ifb.pop, ifb.clr_err} = '0; ifb.data_in = '0;
    {ifc.push, ifc.pop, ifc.clr_err} = '0; ifc.data_in = '0;

    #12;
    chk("rst_count", ifa.count, 0);
    chk("rst_empty", ifa.empty, 1);
    chk("rst_aempty", ifa.almost_empty, 1);
    chk("rst_full", ifa.full, 0);
    chk("rst_afull", ifa.almost_full, 0);
    chk("rst_dout", ifa.data_out, 0);
    chk("rst_valid", ifa.out_valid, 0);
    chk("rst_ovf", ifa.overflow, 0);
    chk("rst_udf", ifa.underflow, 0);
    chk("rst_b_valid", ifb.out_valid, 0);
    tick();
    rstn = 1'b1;

    // Fill with 00..44 including an all-zero word, then drain in order.
    for (int i = 0; i < 5; i++) begin
      ifa.push = 1'b1; ifa.data_in = 8'(i * 8'h11);
      tick();
    end
    ifa.push = 1'b0;
    chk("fill_full", ifa.full, 1);
    chk("fill_count", ifa.count, 5);
    chk("fill_afull", ifa.almost_full, 1);
    for (int i = 0; i < 5; i++) begin
      ifa.pop = 1'b1;
      tick();
      chk("drain_dout", ifa.data_out, 32'(i * 8'h11));
      chk("drain_valid", ifa.out_valid, 1);
    end
    ifa.pop = 1'b0;
    tick();
    chk("drain_valid_end", ifa.out_valid, 0);
    chk("drain_empty", ifa.empty, 1);
    chk("drain_count", ifa.count, 0);
    chk("drain_hold", ifa.data_out, 8'h44);

    // Refill with 50..54, then 7 cycles of simultaneous push/pop across the wrap.
    for (int i = 0; i < 5; i++) begin
      ifa.push = 1'b1; ifa.data_in = 8'(8'h50 + i);
      tick();
    end
    for (int k = 0; k < 7; k++) begin
      ifa.push = 1'b1; ifa.pop = 1'b1; ifa.data_in = 8'(8'h60 + k);
      tick();
      chk("pp_dout", ifa.data_out, (k < 5) ? 32'(8'h50 + k) : 32'(8'h60 + k - 5));
      chk("pp_count", ifa.count, 5);
      chk("pp_full", ifa.full, 1);
    end
    ifa.push = 1'b0; ifa.pop = 1'b0;
    chk("pp_no_ovf", ifa.overflow, 0);

    // Push into a full FIFO: rejected, sticky overflow, contents intact.
    ifa.push = 1'b1; ifa.data_in = 8'hEE;
    tick();
    ifa.push = 1'b0;
    chk("ovf_set", ifa.overflow, 1);
    chk("ovf_count", ifa.count, 5);
    tick();
    chk("ovf_sticky", ifa.overflow, 1);
    ifa.clr_err = 1'b1;
    tick();
    ifa.clr_err = 1'b0;
    chk("ovf_clr", ifa.overflow, 0);
    for (int i = 0; i < 5; i++) begin
      ifa.pop = 1'b1;
      tick();
      chk("ovf_contents", ifa.data_out, 32'(8'h62 + i));
    end
    ifa.pop = 1'b0;

    // Push and pop on an empty FIFO: push taken, pop rejected.
    ifa.push = 1'b1; ifa.pop = 1'b1; ifa.data_in = 8'hA5;
    tick();
    ifa.push = 1'b0; ifa.pop = 1'b0;
    chk("udf_set", ifa.underflow, 1);
    chk("udf_count", ifa.count, 1);
    chk("udf_valid", ifa.out_valid, 0);
    ifa.pop = 1'b1;
    tick();
    ifa.pop = 1'b0;
    chk("udf_word", ifa.data_out, 8'hA5);

    // FWFT: word shows up without a pop.
    ifb.push = 1'b1; ifb.data_in = 8'h3C;
    tick();
    ifb.push = 1'b0;
    chk("fwft_dout", ifb.data_out, 8'h3C);
    chk("fwft_valid", ifb.out_valid, 1);
    tick();
    chk("fwft_hold", ifb.data_out, 8'h3C);
    ifb.pop = 1'b1;
    tick();
    ifb.pop = 1'b0;
    chk("fwft_empty", ifb.empty, 1);
    chk("fwft_valid0", ifb.out_valid, 0);
    for (int i = 1; i <= 2; i++) begin
      ifb.push = 1'b1; ifb.data_in = 8'(i);
      tick();
    end
    ifb.push = 1'b0;
    chk("fwft_head1", ifb.data_out, 8'h01);
    ifb.pop = 1'b1;
    tick();
    ifb.pop = 1'b0;
    chk("fwft_head2", ifb.data_out, 8'h02);

    // Depth-16 thresholds.
    for (int i = 0; i < 2; i++) begin
      ifc.push = 1'b1; ifc.data_in = 8'(i);
      tick();
    end
    ifc.push = 1'b0;
    chk("c_cnt2", ifc.count, 2);
    chk("c_aempty2", ifc.almost_empty, 1);
    ifc.push = 1'b1;
    tick();
    ifc.push = 1'b0;
    chk("c_aempty3", ifc.almost_empty, 0);
    for (int i = 3; i < 13; i++) begin
      ifc.push = 1'b1; ifc.data_in = 8'(i);
      tick();
    end
    ifc.push = 1'b0;
    chk("c_afull13", ifc.almost_full, 0);
    ifc.push = 1'b1;
    tick();
    ifc.push = 1'b0;
    chk("c_cnt14", ifc.count, 14);
    chk("c_afull14", ifc.almost_full, 1);
    for (int i = 0; i < 4; i++) begin
      ifc.pop = 1'b1;
      tick();
    end
    ifc.pop = 1'b0;
    chk("c_cnt10", ifc.count, 10);

    // Asynchronous reset mid-stream with a push pending across an edge.
    ifc.push = 1'b1;
    rstn = 1'b0;
    #1;
    chk("c_arst_count", ifc.count, 0);
    chk("c_arst_empty", ifc.empty, 1);
    tick();
    chk("c_arst_edge", ifc.count, 0);
    ifc.push = 1'b0;
    rstn = 1'b1;
    tick();
    chk("c_after_rst", ifc.empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
